// File: rtl/sobel_kernel_ci.sv
// -----------------------------------------------------------------------------
// sobel_kernel_ci
//
// Custom-instruction stage computing a clamped Sobel gradient magnitude over a
// 3x3 grayscale window that the CPU loads row by row.
//
// Operations (valueB[31:30]):
//   00 LOAD    : row valueB[1:0] <= valueA[23:0] (col0 in [7:0]); row 3 = no write
//   01 COMPUTE : 9 tap cycles, 1 magnitude cycle, done pulse in cycle 11
//   10 CLEAR   : window, Gx and Gy <= 0 (and threshold <= valueA[10:0])
//   11 READ    : result = {sext16(Gy), sext16(Gx)} from the last COMPUTE
//
// Optional build macro: SOBEL_THRESHOLD_EN
//   When defined, CLEAR also loads an 11-bit threshold and COMPUTE returns
//   255 if |Gx|+|Gy| >= threshold, else 0 (instead of the clamped magnitude).
//
// Ports:
//   clock  : system clock, all state updates on the rising edge
//   reset  : synchronous reset, active low
//   start  : one-cycle instruction start strobe
//   ciN    : custom-instruction number, block responds only to customId
//   valueA : operand A (pixels / threshold)
//   valueB : operand B ([31:30] op, [1:0] row index for LOAD)
//   done   : one-cycle completion pulse
//   result : instruction result, forced to zero whenever done is low so the
//            bus can be OR-ed with other custom-instruction units
// -----------------------------------------------------------------------------
module sobel_kernel_ci #(
  parameter logic [7:0] customId = 8'h19
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [1:0] OP_LOAD    = 2'b00;
  localparam logic [1:0] OP_COMPUTE = 2'b01;
  localparam logic [1:0] OP_CLEAR   = 2'b10;
  localparam logic [1:0] OP_READ    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TAP  = 2'd1,
    ST_MAG  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [7:0]         r_pix [0:8];
  logic [3:0]         r_k;
  logic signed [11:0] r_gx;
  logic signed [11:0] r_gy;
  logic [7:0]         r_out;
`ifdef SOBEL_THRESHOLD_EN
  logic [10:0]        r_thr;
`endif

  logic               w_accept;
  logic [1:0]         w_op;
  logic [7:0]         w_pix_sel;
  logic [11:0]        w_px1;
  logic [11:0]        w_px2;
  logic [11:0]        w_dx;
  logic [11:0]        w_dy;
  logic [11:0]        w_abs_gx;
  logic [11:0]        w_abs_gy;
  logic [10:0]        w_mag;
  logic [7:0]         w_out_nxt;
  logic               w_unused_bits;

  assign w_op          = valueB[31:30];
  assign w_unused_bits = ^{valueA[31:24], valueB[29:2]};

  // An instruction is taken only in IDLE; a low reset also blocks acceptance
  // so nothing completes in a cycle whose state is being cleared.
  assign w_accept = start && (ciN == customId) && (r_state == ST_IDLE) && reset;

  // Select the window pixel addressed by the tap counter (row-major order).
  always_comb begin
    w_pix_sel = 8'd0;
    case (r_k)
      4'd0:    w_pix_sel = r_pix[0];
      4'd1:    w_pix_sel = r_pix[1];
      4'd2:    w_pix_sel = r_pix[2];
      4'd3:    w_pix_sel = r_pix[3];
      4'd4:    w_pix_sel = r_pix[4];
      4'd5:    w_pix_sel = r_pix[5];
      4'd6:    w_pix_sel = r_pix[6];
      4'd7:    w_pix_sel = r_pix[7];
      4'd8:    w_pix_sel = r_pix[8];
      default: w_pix_sel = 8'd0;
    endcase
  end

  assign w_px1 = {4'd0, w_pix_sel};
  assign w_px2 = {3'd0, w_pix_sel, 1'b0};

  // Per-tap Gx/Gy contributions; coefficients of +-1/+-2 become pass,
  // shift-by-one and two's-complement negation, so no multiplier is built.
  always_comb begin
    w_dx = 12'd0;
    w_dy = 12'd0;
    case (r_k)
      4'd0:    begin w_dx = 12'd0 - w_px1; w_dy = 12'd0 - w_px1; end
      4'd1:    begin w_dx = 12'd0;         w_dy = 12'd0 - w_px2; end
      4'd2:    begin w_dx = w_px1;         w_dy = 12'd0 - w_px1; end
      4'd3:    begin w_dx = 12'd0 - w_px2; w_dy = 12'd0;         end
      4'd4:    begin w_dx = 12'd0;         w_dy = 12'd0;         end
      4'd5:    begin w_dx = w_px2;         w_dy = 12'd0;         end
      4'd6:    begin w_dx = 12'd0 - w_px1; w_dy = w_px1;         end
      4'd7:    begin w_dx = 12'd0;         w_dy = w_px2;         end
      4'd8:    begin w_dx = w_px1;         w_dy = w_px1;         end
      default: begin w_dx = 12'd0;         w_dy = 12'd0;         end
    endcase
  end

  // |Gx| and |Gy| are at most 1020, so their sum always fits in 11 bits.
  assign w_abs_gx = r_gx[11] ? (12'd0 - r_gx) : r_gx;
  assign w_abs_gy = r_gy[11] ? (12'd0 - r_gy) : r_gy;
  assign w_mag    = w_abs_gx[10:0] + w_abs_gy[10:0];

`ifdef SOBEL_THRESHOLD_EN
  assign w_out_nxt = (w_mag >= r_thr) ? 8'hFF : 8'h00;
`else
  assign w_out_nxt = (w_mag > 11'd255) ? 8'hFF : w_mag[7:0];
`endif

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (w_op == OP_COMPUTE)) begin
          w_state_nxt = ST_TAP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_TAP: begin
        if (r_k == 4'd8) begin
          w_state_nxt = ST_MAG;
        end else begin
          w_state_nxt = ST_TAP;
        end
      end
      ST_MAG:  w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: single-cycle ops answer in their start cycle, COMPUTE in DONE.
  always_comb begin
    done   = 1'b0;
    result = 32'd0;
    if (r_state == ST_DONE) begin
      done   = 1'b1;
      result = {24'd0, r_out};
    end else if (w_accept) begin
      case (w_op)
        OP_LOAD:  done = 1'b1;
        OP_CLEAR: done = 1'b1;
        OP_READ: begin
          done   = 1'b1;
          result = {{4{r_gy[11]}}, r_gy, {4{r_gx[11]}}, r_gx};
        end
        default: done = 1'b0;
      endcase
    end else begin
      done   = 1'b0;
      result = 32'd0;
    end
  end

  // Datapath: window, accumulators, tap counter, result and threshold.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 9; i++) r_pix[i] <= 8'd0;
      r_k   <= 4'd0;
      r_gx  <= 12'sd0;
      r_gy  <= 12'sd0;
      r_out <= 8'd0;
`ifdef SOBEL_THRESHOLD_EN
      r_thr <= 11'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (w_op)
              OP_LOAD: begin
                case (valueB[1:0])
                  2'd0: begin
                    r_pix[0] <= valueA[7:0];
                    r_pix[1] <= valueA[15:8];
                    r_pix[2] <= valueA[23:16];
                  end
                  2'd1: begin
                    r_pix[3] <= valueA[7:0];
                    r_pix[4] <= valueA[15:8];
                    r_pix[5] <= valueA[23:16];
                  end
                  2'd2: begin
                    r_pix[6] <= valueA[7:0];
                    r_pix[7] <= valueA[15:8];
                    r_pix[8] <= valueA[23:16];
                  end
                  default: begin
                    // row index 3 leaves the window untouched
                  end
                endcase
              end
              OP_COMPUTE: begin
                r_gx <= 12'sd0;
                r_gy <= 12'sd0;
                r_k  <= 4'd0;
              end
              OP_CLEAR: begin
                for (int i = 0; i < 9; i++) r_pix[i] <= 8'd0;
                r_gx <= 12'sd0;
                r_gy <= 12'sd0;
`ifdef SOBEL_THRESHOLD_EN
                r_thr <= valueA[10:0];
`endif
              end
              default: begin
                // READ has no side effects
              end
            endcase
          end
        end
        ST_TAP: begin
          r_gx <= r_gx + $signed(w_dx);
          r_gy <= r_gy + $signed(w_dy);
          r_k  <= r_k + 4'd1;
        end
        ST_MAG: begin
          r_out <= w_out_nxt;
        end
        default: begin
          // DONE holds all state; Gx/Gy stay visible to READ
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_kernel_ci.sv
module tb_sobel_kernel_ci;

  localparam logic [7:0] CUST_ID = 8'h19;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  ciN;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_pix [9];
  int m_gx;
  int m_gy;
  int m_thr;

  sobel_kernel_ci #(.customId(CUST_ID)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .ciN   (ciN),
    .valueA(valueA),
    .valueB(valueB),
    .done  (done),
    .result(result)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 9; i++) m_pix[i] = 0;
    m_gx  = 0;
    m_gy  = 0;
    m_thr = 0;
  endfunction

  // Sobel over the model window using ordinary integer arithmetic.
  function automatic int model_compute();
    int cx [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    int cy [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
    int gx = 0;
    int gy = 0;
    int mag;
    for (int k = 0; k < 9; k++) begin
      gx += cx[k] * m_pix[k];
      gy += cy[k] * m_pix[k];
    end
    m_gx = gx;
    m_gy = gy;
    mag  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESHOLD_EN
    return (mag >= m_thr) ? 255 : 0;
`else
    return (mag > 255) ? 255 : mag;
`endif
  endfunction

  function automatic logic [31:0] model_read();
    logic [31:0] v;
    v = {m_gy[15:0], m_gx[15:0]};
    return v;
  endfunction

  // One single-cycle instruction; outputs sampled mid-cycle.
  task automatic ci_simple(input logic [1:0] op, input logic [1:0] row, input logic [31:0] a,
                           input logic [7:0] id, output logic d, output logic [31:0] r);
    @(negedge clock);
    start  = 1'b1;
    ciN    = id;
    valueA = a;
    valueB = {op, 28'd0, row};
    #2;
    d = done;
    r = result;
    @(posedge clock);
    #1;
    start  = 1'b0;
    valueA = 32'd0;
    valueB = 32'd0;
    ciN    = CUST_ID;
  endtask

  task automatic do_load(input int row, input int c0, input int c1, input int c2);
    logic d;
    logic [31:0] r;
    logic [31:0] a;
    a = {8'd0, c2[7:0], c1[7:0], c0[7:0]};
    ci_simple(2'b00, row[1:0], a, CUST_ID, d, r);
    check_eq("load_done", {31'd0, d}, 32'd1);
    check_eq("load_result", r, 32'd0);
    if (row < 3) begin
      m_pix[row*3]   = c0;
      m_pix[row*3+1] = c1;
      m_pix[row*3+2] = c2;
    end
  endtask

  task automatic load_rows(input int r0, input int r1, input int r2);
    do_load(0, r0 & 255, (r0 >> 8) & 255, (r0 >> 16) & 255);
    do_load(1, r1 & 255, (r1 >> 8) & 255, (r1 >> 16) & 255);
    do_load(2, r2 & 255, (r2 >> 8) & 255, (r2 >> 16) & 255);
  endtask

  task automatic do_clear(input int a);
    logic d;
    logic [31:0] r;
    ci_simple(2'b10, 2'd0, a, CUST_ID, d, r);
    check_eq("clear_done", {31'd0, d}, 32'd1);
    check_eq("clear_result", r, 32'd0);
    for (int i = 0; i < 9; i++) m_pix[i] = 0;
    m_gx = 0;
    m_gy = 0;
`ifdef SOBEL_THRESHOLD_EN
    m_thr = a & 2047;
`endif
  endtask

  task automatic do_read(input string tag, input logic [31:0] exp);
    logic d;
    logic [31:0] r;
    ci_simple(2'b11, 2'd0, $urandom, CUST_ID, d, r);
    check_eq({tag, "_done"}, {31'd0, d}, 32'd1);
    check_eq(tag, r, exp);
  endtask

  // COMPUTE with latency, single-pulse and idle-bus-zero checks.
  task automatic do_compute(input string tag, input int exp, input bit second_start);
    int first = -1;
    int pulses = 0;
    int bus_bad = 0;
    logic [31:0] res = 32'd0;
    @(negedge clock);
    start  = 1'b1;
    ciN    = CUST_ID;
    valueA = $urandom;
    valueB = {2'b01, 30'd0};
    #2;
    check_eq({tag, "_start_done"}, {31'd0, done}, 32'd0);
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clock);
      if (second_start && cyc == 3) begin
        start  = 1'b1;
        valueB = {2'b01, 30'd0};
      end
      #2;
      if (done) begin
        pulses++;
        if (first < 0) begin
          first = cyc;
          res   = result;
        end
      end else if (result != 32'd0) begin
        bus_bad++;
      end
      @(posedge clock);
      #1;
      start = 1'b0;
    end
    check_eq({tag, "_latency"}, first, 32'd11);
    check_eq({tag, "_pulses"}, pulses, 32'd1);
    check_eq({tag, "_result"}, res, exp);
    check_eq({tag, "_idle_bus"}, bus_bad, 32'd0);
  endtask

  initial begin
    logic d;
    logic [31:0] r;
    int exp;
    int pulses;

    reset  = 1'b0;
    start  = 1'b0;
    ciN    = CUST_ID;
    valueA = 32'd0;
    valueB = 32'd0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_eq("reset_done", {31'd0, done}, 32'd0);
    check_eq("reset_result", result, 32'd0);
    reset = 1'b1;

    do_read("reset_read", 32'd0);

    // vertical edge, maximum Gx
    load_rows(32'hFF0000, 32'hFF0000, 32'hFF0000);
    exp = model_compute();
    do_compute("edge", exp, 1'b0);
    do_read("edge_read", 32'h000003FC);

    // horizontal ramp
    load_rows(32'h1E140A, 32'h1E140A, 32'h1E140A);
    exp = model_compute();
    do_compute("ramp", exp, 1'b0);
    do_read("ramp_read", 32'h00000050);

    // positive / negative vertical gradient
    load_rows(32'h000000, 32'h070707, 32'h323232);
    exp = model_compute();
    do_compute("gy_pos", exp, 1'b0);
    do_read("gy_pos_read", 32'h00C80000);
    load_rows(32'h323232, 32'h070707, 32'h000000);
    exp = model_compute();
    do_compute("gy_neg", exp, 1'b1);
    do_read("gy_neg_read", 32'hFF380000);

    // uniform window
    load_rows(32'h646464, 32'h646464, 32'h646464);
    exp = model_compute();
    do_compute("uniform", exp, 1'b0);
    do_read("uniform_read", 32'd0);

    // wrong instruction number: no response, window unchanged
    ci_simple(2'b00, 2'd0, 32'h00FFFFFF, 8'h18, d, r);
    check_eq("wrong_id_done", {31'd0, d}, 32'd0);
    check_eq("wrong_id_result", r, 32'd0);
    // row index 3 must not write
    do_load(3, 255, 0, 9);
    exp = model_compute();
    do_compute("no_change", exp, 1'b0);
    do_read("no_change_read", model_read());

    // reset in cycle 5 of a COMPUTE
    load_rows(32'hFF0000, 32'hFF0000, 32'hFF0000);
    @(negedge clock);
    start  = 1'b1;
    valueB = {2'b01, 30'd0};
    @(posedge clock);
    #1;
    start  = 1'b0;
    pulses = 0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clock);
      reset = (cyc == 5) ? 1'b0 : 1'b1;
      #2;
      if (cyc > 5 && done) pulses++;
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    model_reset();
    check_eq("abort_no_done", pulses, 32'd0);
    do_read("abort_read", 32'd0);
    exp = model_compute();
    do_compute("abort_recompute", exp, 1'b0);

`ifdef SOBEL_THRESHOLD_EN
    do_clear(300);
    load_rows(32'hFF0000, 32'hFF0000, 32'hFF0000);
    exp = model_compute();
    do_compute("thr_edge", exp, 1'b0);
    check_eq("thr_edge_const", exp, 32'd255);
    load_rows(32'h1E140A, 32'h1E140A, 32'h1E140A);
    exp = model_compute();
    do_compute("thr_below", exp, 1'b0);
    do_clear(80);
    load_rows(32'h1E140A, 32'h1E140A, 32'h1E140A);
    exp = model_compute();
    do_compute("thr_equal", exp, 1'b0);
    do_clear(0);
`else
    do_clear($urandom);
`endif
    do_read("clear_read", 32'd0);

    // randomized windows
    for (int it = 0; it < 20; it++) begin
      for (int row = 0; row < 4; row++) begin
        int v [3];
        for (int c = 0; c < 3; c++) begin
          if ($urandom_range(3) == 0) v[c] = $urandom_range(1) ? 255 : 0;
          else v[c] = $urandom_range(255);
        end
        do_load(row, v[0], v[1], v[2]);
      end
      exp = model_compute();
      do_compute("rand", exp, it[0]);
      do_read("rand_read", model_read());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
